usb_bit_stuffer: RTL and testbench
==================================

# usb_bit_stuffer

USB transmit-path bit stuffer: after a configurable run of consecutive 1 bits, it inserts a single 0 into the serial stream. It sits between the TX shift register (source of `d_orig`) and the NRZI encoder (sink of `d_data`). It back-pressures the shift register with `pause` for the stuffed bit time.

## Interface
- `MAX_ONES`, default 6: run length of consecutive 1s that triggers a stuffed 0. Legal range 1..15.
- `clk` input 1: single clock; all state updates on its rising edge.
- `n_rst` input 1: synchronous, active-high reset, sampled on the rising edge of `clk`. The codebase port name is kept despite the `n_` prefix.
- `d_orig` input 1: unstuffed serial data bit offered by the upstream shift register.
- `d_data` output 1: stuffed serial data bit to the NRZI encoder.
- `pause` output 1: high during a stuffed-bit cycle. Upstream must hold `d_orig` and not advance while `pause` is high.

## Operation
- Internal state: `ones_cnt`, width `$clog2(MAX_ONES+1)`. It counts consecutive accepted 1 bits.
- Outputs are combinational from state and input:
  - `pause = (ones_cnt == MAX_ONES)`.
  - `d_data = pause ? 0 : d_orig`.
  - While `n_rst` is high, `d_data` is forced to 1 (idle) and `pause` is forced to 0.
- A bit is accepted in any cycle with `pause == 0`.
- `ones_cnt` update at each rising edge, highest priority first:
  - `n_rst` high: `ones_cnt` becomes 0.
  - `pause` high: `ones_cnt` becomes 0 (the stuffed 0 breaks the run; `d_orig` is ignored).
  - `d_orig` high: `ones_cnt` becomes `ones_cnt + 1`.
  - Otherwise: `ones_cnt` becomes 0.
- A naturally occurring 0 resets the run, so no stuffing follows it.
- A stuffed 0 also resets the run. Thirteen consecutive 1s therefore produce stuffs after bits 6 and 12.
- `ones_cnt` never exceeds `MAX_ONES`. No wrap-around is possible.

## Timing
- Zero-cycle latency: `d_data` follows `d_orig` combinationally in non-pause cycles.
- `pause` rises in the cycle after the `MAX_ONES`-th consecutive 1 is accepted. It is high for exactly one cycle.
- Handshake: upstream samples `pause` before its shift edge. When `pause` is 1, upstream holds its current bit. That bit is accepted on the following cycle.
- Reset value after the first rising edge with `n_rst` high: `ones_cnt = 0`, `pause = 0`, `d_data = 1`.
- Reset mid-run or during a pause cycle: the count clears on that edge. No stuffed bit is emitted after reset release.
- Reset has priority over all other events on the same edge.

## Configuration
- Macro `BIT_STUFFER_BYPASS_EN`.
- Defined:
  - Adds input port `bypass` (1 bit).
  - While `bypass` is high: `d_data = d_orig`, `pause = 0`, and `ones_cnt` is held at 0.
  - When `bypass` deasserts, counting restarts from 0.
- Not defined:
  - The `bypass` port is absent.
  - Stuffing is always active.

## Test plan
- Reset: hold `n_rst` = 1 for 1 cycle with `d_orig` = 1 -> `pause` = 0 and `d_data` = 1. After release, `ones_cnt` starts at 0.
- Run of 12 bits, MSB first, with upstream shifting only when `pause` = 0:
  - Input: `1010_1111_1110`.
  - Expected `d_data` over 13 cycles: `1,0,1,0,1,1,1,1,1,1,0(stuffed),1,0`.
  - `pause` high only in cycle 11.
- Exactly 5 ones then a 0 (`0111110`) -> no pause; `d_data` equals input.
- 13 consecutive 1s -> stuffed 0s after input bits 6 and 12. `pause` is high twice and the stream is 15 bits long.
- Reset asserted during the pause cycle -> the next edge clears the count. After release, 6 more 1s are needed before the next `pause`.
- With `BIT_STUFFER_BYPASS_EN` and `bypass` = 1, 10 consecutive 1s -> `pause` stays 0 and `d_data` equals `d_orig`.

Source files
------------

// File: rtl/usb_bit_stuffer.sv
// USB transmit bit stuffer: inserts a 0 after MAX_ONES consecutive 1s and pauses upstream for that bit.
// Optional macro BIT_STUFFER_BYPASS_EN adds a `bypass` input that passes data through unstuffed.
module usb_bit_stuffer #(
  parameter int unsigned MAX_ONES = 6
) (
  input  logic clk,
  input  logic n_rst,
`ifdef BIT_STUFFER_BYPASS_EN
  input  logic bypass,
`endif
  input  logic d_orig,
  output logic d_data,
  output logic pause
);

  localparam int unsigned CNT_W = $clog2(MAX_ONES + 1);

  logic [CNT_W-1:0] ones_cnt_q;
  logic [CNT_W-1:0] ones_cnt_d;
  logic             run_full;
  logic             bypass_active;

`ifdef BIT_STUFFER_BYPASS_EN
  assign bypass_active = bypass;
`else
  assign bypass_active = 1'b0;
`endif

  assign run_full = (ones_cnt_q == CNT_W'(MAX_ONES));

  // Outputs are combinational; reset forces the line idle (1) with no pause.
  always_comb begin
    pause  = 1'b0;
    d_data = d_orig;
    if (n_rst) begin
      d_data = 1'b1;
    end else if (!bypass_active && run_full) begin
      pause  = 1'b1;
      d_data = 1'b0;
    end
  end

  // Run-length count of accepted 1s; a stuffed or natural 0 ends the run.
  always_comb begin
    ones_cnt_d = '0;
    if (n_rst || bypass_active) begin
      ones_cnt_d = '0;
    end else if (run_full) begin
      ones_cnt_d = '0;
    end else if (d_orig) begin
      ones_cnt_d = ones_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    ones_cnt_q <= ones_cnt_d;
  end

endmodule

// File: tb/tb_usb_bit_stuffer.sv
// Self-checking bench for usb_bit_stuffer: table vectors, hand corner sequences, random streams vs. a stream model.
module tb_usb_bit_stuffer;

  localparam int unsigned MAX_ONES = 6;

  typedef bit bq_t[$];

  typedef struct {
    logic [31:0] in_bits;
    int unsigned in_len;
    logic [31:0] exp_data;
    logic [31:0] exp_pause;
    int unsigned exp_len;
  } vec_t;

  logic clk;
  logic n_rst;
  logic d_orig;
  logic d_data;
  logic pause;
`ifdef BIT_STUFFER_BYPASS_EN
  logic bypass;
`endif

  int checks;
  int errors;

  usb_bit_stuffer #(.MAX_ONES(MAX_ONES)) dut (
    .clk    (clk),
    .n_rst  (n_rst),
`ifdef BIT_STUFFER_BYPASS_EN
    .bypass (bypass),
`endif
    .d_orig (d_orig),
    .d_data (d_data),
    .pause  (pause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Stream-level reference: copy each bit, append a 0 after every MAX_ONES-long run of 1s.
  function automatic void ref_stuff(input bq_t in_bits, output bq_t e_data, output bq_t e_pause);
    int run;
    run = 0;
    e_data = {};
    e_pause = {};
    foreach (in_bits[i]) begin
      e_data.push_back(in_bits[i]);
      e_pause.push_back(1'b0);
      run = in_bits[i] ? run + 1 : 0;
      if (run == int'(MAX_ONES)) begin
        e_data.push_back(1'b0);
        e_pause.push_back(1'b1);
        run = 0;
      end
    end
  endfunction

  // Hold reset one cycle with d_orig=1; outputs must read idle. Returns at posedge+1.
  task automatic do_reset(input string tag);
    n_rst  = 1'b1;
    d_orig = 1'b1;
    @(negedge clk);
    check({tag, "_rst_pause"}, int'(pause), 0);
    check({tag, "_rst_data"}, int'(d_data), 1);
    @(posedge clk);
    #1;
    n_rst = 1'b0;
  endtask

  // Act as upstream: offer bits, advance only in cycles where pause was low.
  task automatic run_stream(input bq_t in_bits, output bq_t o_data, output bq_t o_pause,
                            output int accepted);
    int cyc;
    accepted = 0;
    cyc = 0;
    o_data = {};
    o_pause = {};
    while (accepted < in_bits.size() && cyc < 4 * in_bits.size() + 8) begin
      d_orig = in_bits[accepted];
      @(negedge clk);
      o_data.push_back(d_data);
      o_pause.push_back(pause);
      if (!pause) accepted++;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic compare_streams(input string tag, input bq_t g_data, input bq_t g_pause,
                                 input bq_t e_data, input bq_t e_pause);
    int n;
    check({tag, "_len"}, g_data.size(), e_data.size());
    n = (g_data.size() < e_data.size()) ? g_data.size() : e_data.size();
    for (int j = 0; j < n; j++) begin
      check($sformatf("%s_data%0d", tag, j), int'(g_data[j]), int'(e_data[j]));
      check($sformatf("%s_pause%0d", tag, j), int'(g_pause[j]), int'(e_pause[j]));
    end
  endtask

  vec_t vecs[4];

  initial begin
    bq_t in_q, g_data, g_pause, e_data, e_pause;
    int acc;
    string tag;
    checks = 0;
    errors = 0;
    n_rst  = 1'b1;
    d_orig = 1'b1;
`ifdef BIT_STUFFER_BYPASS_EN
    bypass = 1'b0;
`endif

    vecs[0] = '{32'b1010_1111_1110, 12, 32'b1010111111010, 32'b0000000000100, 13};
    vecs[1] = '{32'b0111110, 7, 32'b0111110, 32'b0000000, 7};
    vecs[2] = '{32'h1FFF, 13, 32'b111111011111101, 32'b000000100000010, 15};
    vecs[3] = '{32'b1111110, 7, 32'b11111100, 32'b00000010, 8};

    @(posedge clk);
    #1;

    // Table vectors, expected streams derived by hand.
    for (int i = 0; i < 4; i++) begin
      tag = $sformatf("vec%0d", i);
      do_reset(tag);
      in_q = {};
      e_data = {};
      e_pause = {};
      for (int k = 0; k < int'(vecs[i].in_len); k++)
        in_q.push_back(vecs[i].in_bits[vecs[i].in_len - 1 - k]);
      for (int k = 0; k < int'(vecs[i].exp_len); k++) begin
        e_data.push_back(vecs[i].exp_data[vecs[i].exp_len - 1 - k]);
        e_pause.push_back(vecs[i].exp_pause[vecs[i].exp_len - 1 - k]);
      end
      run_stream(in_q, g_data, g_pause, acc);
      check({tag, "_accepted"}, acc, in_q.size());
      compare_streams(tag, g_data, g_pause, e_data, e_pause);
    end

    // Reset during the pause cycle: count clears, a full fresh run is needed again.
    do_reset("rp");
    d_orig = 1'b1;
    for (int k = 0; k < int'(MAX_ONES); k++) begin
      @(negedge clk);
      check($sformatf("rp_pre_pause%0d", k), int'(pause), 0);
      @(posedge clk);
      #1;
    end
    check("rp_pause_up", int'(pause), 1);
    check("rp_stuff_bit", int'(d_data), 0);
    n_rst = 1'b1;
    @(negedge clk);
    check("rp_forced_pause", int'(pause), 0);
    check("rp_forced_data", int'(d_data), 1);
    @(posedge clk);
    #1;
    n_rst = 1'b0;
    for (int k = 0; k < int'(MAX_ONES); k++) begin
      @(negedge clk);
      check($sformatf("rp_post_pause%0d", k), int'(pause), 0);
      check($sformatf("rp_post_data%0d", k), int'(d_data), 1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("rp_post_stuff", int'(pause), 1);
    @(posedge clk);
    #1;

    // Mid-run reset: 4 ones, reset, then 5 ones must not stuff.
    do_reset("mr");
    d_orig = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    do_reset("mr2");
    d_orig = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    check("mr_no_pause", int'(pause), 0);
    @(posedge clk);
    #1;

`ifdef BIT_STUFFER_BYPASS_EN
    // Bypass: no stuffing, data passes through, count restarts at 0 afterwards.
    do_reset("bp");
    bypass = 1'b1;
    for (int k = 0; k < 10; k++) begin
      d_orig = 1'b1;
      @(negedge clk);
      check($sformatf("bp_pause%0d", k), int'(pause), 0);
      check($sformatf("bp_data%0d", k), int'(d_data), 1);
      @(posedge clk);
      #1;
    end
    d_orig = 1'b0;
    @(negedge clk);
    check("bp_data_zero", int'(d_data), 0);
    @(posedge clk);
    #1;
    d_orig = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bypass = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_restart_no_pause", int'(pause), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_restart_stuff", int'(pause), 1);
    @(posedge clk);
    #1;
`endif

    // Random streams biased toward 1s, checked against the stream model.
    for (int r = 0; r < 20; r++) begin
      int len;
      tag = $sformatf("rnd%0d", r);
      do_reset(tag);
      len = int'($urandom_range(8, 40));
      in_q = {};
      for (int k = 0; k < len; k++) in_q.push_back($urandom_range(0, 4) != 0);
      in_q.push_back(1'b0);
      ref_stuff(in_q, e_data, e_pause);
      run_stream(in_q, g_data, g_pause, acc);
      check({tag, "_accepted"}, acc, in_q.size());
      compare_streams(tag, g_data, g_pause, e_data, e_pause);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
